// File: rtl/snake_step_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_step_ctrl_if : raster, button and game-status bundle         |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface snake_step_ctrl_if;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic       display_on;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       btn_start;
   logic [1:0] state;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic       step;
   logic [9:0] score;
   logic       head_pix;

   modport slave (
      input  pos_x, pos_y, display_on,
      input  btn_up, btn_down, btn_left, btn_right, btn_start,
      output state, head_x, head_y, step, score, head_pix
   );

   modport master (
      output pos_x, pos_y, display_on,
      output btn_up, btn_down, btn_left, btn_right, btn_start,
      input  state, head_x, head_y, step, score, head_pix
   );
endinterface
`default_nettype wire

// File: rtl/snake_step_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_step_ctrl : frame-paced head stepping and IDLE/RUN/DEAD FSM  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module snake_step_ctrl #(
   parameter int GRID_W          = 40,
   parameter int GRID_H          = 30,
   parameter int CELL_SHIFT      = 4,
   parameter int V_ACTIVE        = 480,
   parameter int FRAMES_PER_STEP = 8,
   parameter int START_X         = 20,
   parameter int START_Y         = 15
) (
   input  wire logic        clk,
   input  wire logic        reset,
   snake_step_ctrl_if.slave bus
);

   localparam int C_FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [C_FCW-1:0] c_FC_LAST = C_FCW'(FRAMES_PER_STEP - 1);
   localparam logic [5:0] c_START_X = 6'(START_X);
   localparam logic [4:0] c_START_Y = 5'(START_Y);
   localparam logic [5:0] c_X_MAX   = 6'(GRID_W - 1);
   localparam logic [4:0] c_Y_MAX   = 5'(GRID_H - 1);
   localparam logic [9:0] c_VBLANK  = 10'(V_ACTIVE);
   localparam logic [9:0] c_SC_MAX  = 10'd1023;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   // Encoding chosen so that the reverse of a direction is bit 0 inverted.
   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   state_t           r_state;
   state_t           w_state_nxt;
   dir_t             r_dir;
   dir_t             r_pend;
   dir_t             w_cand;
   logic             w_cand_vld;
   logic             w_accept;
   logic [C_FCW-1:0] r_frame_cnt;
   logic [5:0]       r_head_x;
   logic [4:0]       r_head_y;
   logic [5:0]       w_nx;
   logic [4:0]       w_ny;
   logic             w_oob;
   logic             w_fs;
   logic             w_step_fire;
   logic             w_restart;
   logic             w_pix_hit;
   logic             r_step;
   logic             r_head_pix;
   logic [9:0]       r_score;

   assign w_fs        = (bus.pos_y == c_VBLANK) && (bus.pos_x == 10'd0);
   assign w_step_fire = (r_state == ST_RUN) && w_fs && (r_frame_cnt == c_FC_LAST);
   assign w_pix_hit   = bus.display_on
                        && ((bus.pos_x >> CELL_SHIFT) == {4'd0, r_head_x})
                        && ((bus.pos_y >> CELL_SHIFT) == {5'd0, r_head_y});

   always_comb begin
      w_cand_vld = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
      w_cand     = DIR_RIGHT;
      if (bus.btn_up)
         w_cand = DIR_UP;
      else if (bus.btn_down)
         w_cand = DIR_DOWN;
      else if (bus.btn_left)
         w_cand = DIR_LEFT;
      w_accept = w_cand_vld && (w_cand != dir_t'({r_dir[1], ~r_dir[0]}));
   end

   always_comb begin
      w_nx  = r_head_x;
      w_ny  = r_head_y;
      w_oob = 1'b0;
      case (r_pend)
         DIR_UP:    if (r_head_y == 5'd0)    w_oob = 1'b1; else w_ny = r_head_y - 5'd1;
         DIR_DOWN:  if (r_head_y == c_Y_MAX) w_oob = 1'b1; else w_ny = r_head_y + 5'd1;
         DIR_LEFT:  if (r_head_x == 6'd0)    w_oob = 1'b1; else w_nx = r_head_x - 6'd1;
         default:   if (r_head_x == c_X_MAX) w_oob = 1'b1; else w_nx = r_head_x + 6'd1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      case (r_state)
         ST_IDLE: if (bus.btn_start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_step_fire && w_oob) w_state_nxt = ST_DEAD;
         ST_DEAD: begin
            if (bus.btn_start) begin
               w_state_nxt = ST_IDLE;
               w_restart   = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head_x    <= c_START_X;
         r_head_y    <= c_START_Y;
         r_dir       <= DIR_RIGHT;
         r_pend      <= DIR_RIGHT;
         r_frame_cnt <= '0;
         r_step      <= 1'b0;
         r_score     <= '0;
         r_head_pix  <= 1'b0;
      end else begin
         r_step     <= w_step_fire;
         r_head_pix <= w_pix_hit;

         if (r_state != ST_RUN)
            r_frame_cnt <= '0;
         else if (w_fs)
            r_frame_cnt <= (r_frame_cnt == c_FC_LAST) ? '0 : r_frame_cnt + 1'b1;

         if (w_restart) begin
            r_head_x <= c_START_X;
            r_head_y <= c_START_Y;
            r_dir    <= DIR_RIGHT;
            r_pend   <= DIR_RIGHT;
            r_score  <= '0;
         end else if (r_state == ST_RUN) begin
            // Capture is suspended on the step edge so a request is always
            // judged against the direction that is actually committed.
            if (w_step_fire) begin
               r_dir <= r_pend;
               if (!w_oob) begin
                  r_head_x <= w_nx;
                  r_head_y <= w_ny;
                  if (r_score != c_SC_MAX)
                     r_score <= r_score + 10'd1;
               end
            end else if (w_accept) begin
               r_pend <= w_cand;
            end
         end
      end
   end

   assign bus.state    = r_state;
   assign bus.head_x   = r_head_x;
   assign bus.head_y   = r_head_y;
   assign bus.step     = r_step;
   assign bus.score    = r_score;
   assign bus.head_pix = r_head_pix;

endmodule
`default_nettype wire

// File: tb/tb_snake_step_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_snake_step_ctrl : step scoreboard plus head_pix vector table    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_snake_step_ctrl;

   localparam int FPS = 8;

   typedef struct {
      int hx;
      int hy;
      int st;
      int sc;
   } step_t;

   typedef struct {
      int px;
      int py;
      int don;
      int exp_pix;
   } pix_vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   step_t q[$];

   snake_step_ctrl_if bus ();

   snake_step_ctrl #(
      .GRID_W(40), .GRID_H(30), .CELL_SHIFT(4), .V_ACTIVE(480),
      .FRAMES_PER_STEP(FPS), .START_X(20), .START_Y(15)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      step_t e;
      if (reset && bus.step) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL step_unexpected actual=1 required=0 at t=%0t", $time);
         end else begin
            e = q.pop_front();
            chk("step_head_x", int'(bus.head_x), e.hx);
            chk("step_head_y", int'(bus.head_y), e.hy);
            chk("step_state",  int'(bus.state),  e.st);
            chk("step_score",  int'(bus.score),  e.sc);
         end
      end
   end

   initial begin
      #(4_000_000);
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic frame();
      @(negedge clk);
      bus.pos_x = 10'd0;
      bus.pos_y = 10'd480;
      @(negedge clk);
      bus.pos_x = 10'd1;
      bus.pos_y = 10'd0;
   endtask

   task automatic do_step(input int hx, input int hy, input int st, input int sc);
      step_t e;
      e.hx = hx; e.hy = hy; e.st = st; e.sc = sc;
      for (int i = 0; i < FPS; i++) begin
         if (i == FPS - 1) q.push_back(e);
         frame();
      end
      @(negedge clk);
      chk("step_seen", q.size(), 0);
   endtask

   task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
      bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
   endtask

   task automatic restart_from_dead();
      @(negedge clk);
      bus.btn_start = 1'b1;
      @(negedge clk);
      chk("restart_idle_state", int'(bus.state), 0);
      chk("restart_head_x", int'(bus.head_x), 20);
      chk("restart_head_y", int'(bus.head_y), 15);
      chk("restart_score", int'(bus.score), 0);
      @(negedge clk);
      chk("restart_run_state", int'(bus.state), 1);
      bus.btn_start = 1'b0;
   endtask

   pix_vec_t vec [12];

   initial begin
      vec[0]  = '{48, 32, 1, 1};
      vec[1]  = '{63, 47, 1, 1};
      vec[2]  = '{47, 32, 1, 0};
      vec[3]  = '{64, 32, 1, 0};
      vec[4]  = '{48, 31, 1, 0};
      vec[5]  = '{48, 48, 1, 0};
      vec[6]  = '{55, 40, 0, 0};
      vec[7]  = '{50, 40, 1, 1};
      vec[8]  = '{0,  0,  1, 0};
      vec[9]  = '{63, 32, 1, 1};
      vec[10] = '{48, 47, 1, 1};
      vec[11] = '{100, 200, 1, 0};

      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      bus.pos_x = 10'd1;
      bus.pos_y = 10'd0;
      bus.display_on = 1'b0;
      bus.btn_start  = 1'b0;
      set_btn(0, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("rst_state", int'(bus.state), 0);
      chk("rst_head_x", int'(bus.head_x), 20);
      chk("rst_head_y", int'(bus.head_y), 15);
      chk("rst_step", int'(bus.step), 0);
      chk("rst_score", int'(bus.score), 0);
      chk("rst_head_pix", int'(bus.head_pix), 0);
      reset = 1'b1;

      @(negedge clk);
      bus.btn_start = 1'b1;
      @(negedge clk);
      bus.btn_start = 1'b0;
      chk("start_run_state", int'(bus.state), 1);

      do_step(21, 15, 1, 1);
      set_btn(0, 0, 1, 0);
      do_step(22, 15, 1, 2);
      set_btn(1, 0, 0, 0);
      do_step(22, 14, 1, 3);
      set_btn(0, 0, 0, 1);
      do_step(23, 14, 1, 4);
      set_btn(1, 0, 0, 1);
      do_step(23, 13, 1, 5);
      set_btn(0, 0, 0, 1);
      for (int x = 24; x <= 39; x++) do_step(x, 13, 1, x - 18);
      do_step(39, 13, 2, 21);
      set_btn(0, 0, 0, 0);
      chk("dead_state", int'(bus.state), 2);

      restart_from_dead();
      for (int k = 1; k <= 19; k++) do_step(20 + k, 15, 1, k);
      do_step(39, 15, 2, 19);
      frame();
      chk("dead_hold_score", int'(bus.score), 19);

      restart_from_dead();
      set_btn(1, 0, 0, 0);
      for (int k = 1; k <= 13; k++) do_step(20, 15 - k, 1, k);
      set_btn(0, 0, 1, 0);
      for (int k = 1; k <= 17; k++) do_step(20 - k, 2, 1, 13 + k);
      set_btn(0, 0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.pos_x = 10'(vec[i].px);
         bus.pos_y = 10'(vec[i].py);
         bus.display_on = vec[i].don[0];
         @(negedge clk);
         chk($sformatf("pix_vec%0d", i), int'(bus.head_pix), vec[i].exp_pix);
      end

      bus.display_on = 1'b0;
      repeat (3) frame();
      @(negedge clk);
      bus.pos_x = 10'd50;
      bus.pos_y = 10'd40;
      bus.display_on = 1'b1;
      @(negedge clk);
      chk("pix_pre_reset", int'(bus.head_pix), 1);
      #5 reset = 1'b0;
      #1;
      chk("midrst_state", int'(bus.state), 0);
      chk("midrst_head_x", int'(bus.head_x), 20);
      chk("midrst_head_y", int'(bus.head_y), 15);
      chk("midrst_step", int'(bus.step), 0);
      chk("midrst_score", int'(bus.score), 0);
      chk("midrst_head_pix", int'(bus.head_pix), 0);
      @(negedge clk);
      bus.display_on = 1'b0;
      bus.pos_x = 10'd1;
      bus.pos_y = 10'd0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_state", int'(bus.state), 0);

      bus.btn_start = 1'b1;
      @(negedge clk);
      bus.btn_start = 1'b0;
      do_step(21, 15, 1, 1);

      repeat (4) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
